cnn_load_ctrl: RTL

Frame controller between the UART nibble receiver and the CNN core. It parses a command nibble, then streams the following nibbles into the coefficient, bias or image memory one nibble per address. When a frame is complete it pulses the CNN start and waits for the core's completion. Image-only frames reuse the resident parameters, so the network is not reloaded per inference.

---
 rtl/cnn_load_pkg.sv | 32 +++
 rtl/cnn_load_ctrl_gap_timer.sv | 38 +++
 rtl/cnn_load_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_load_pkg.sv
// Shared definitions for the CNN load controller.
//   state_t           : controller FSM states
//   SEL_*             : memory region select codes driven on mem_sel_o
//   CMD_*             : command nibbles accepted in IDLE
//   *_N_DEF           : default region sizes in nibbles
//   TIMEOUT_DEF       : default max idle clocks between nibbles in a frame
package cnn_load_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_COEF = 3'd1,
        S_LD_BIAS = 3'd2,
        S_LD_IMG  = 3'd3,
        S_START   = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    localparam logic [1:0] SEL_COEF = 2'd0;
    localparam logic [1:0] SEL_BIAS = 2'd1;
    localparam logic [1:0] SEL_IMG  = 2'd2;

    localparam logic [3:0] CMD_FULL = 4'h1;
    localparam logic [3:0] CMD_IMG  = 4'h2;

    localparam int unsigned COEF_N_DEF  = 34720;
    localparam int unsigned BIAS_N_DEF  = 106;
    localparam int unsigned IMG_N_DEF   = 784;
    localparam int unsigned TIMEOUT_DEF = 100000;

    localparam int ADDR_W = 16;

endpackage

// File: rtl/cnn_load_ctrl_gap_timer.sv
// Idle-gap timer for frame loading.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (takes priority)
//   enable     : count one clock per cycle while high
//   expire     : high while the TIMEOUT_CYC-th consecutive idle clock is in
//                progress; the consumer acts on it at the next edge
module gap_timer
    import cnn_load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // expire depends only on the register and enable, so the FSM may use it
    // to build the clear term without forming a combinational loop.
    assign expire = enable && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_load_ctrl.sv
// Frame controller between the UART nibble receiver and the CNN core.
// A command nibble selects a full load (coef, bias, image) or an image-only
// load; the following nibbles are written one per address into the selected
// region, then the CNN is started and its completion awaited.
//   rx_valid_i/rx_nibble_i : received nibble strobe and data
//   mem_we_o/sel/addr/wdata: registered memory write port
//   cnn_start_o/cnn_done_i : CNN start pulse and completion input
//   busy_o                 : controller not idle
//   params_valid_o         : coef and bias resident
//   frame_done_o           : one-cycle pulse after CNN completion
//   err_*_o                : sticky error flags, cleared by an accepted command
//   dbg_state_o            : current FSM state for observation
// Handshake: rx_valid_i is a single-cycle strobe with no back-pressure; every
// strobe is consumed in the cycle it is seen (written, taken as a command,
// or dropped and flagged).
module cnn_load_ctrl
    import cnn_load_pkg::*;
#(
    parameter int unsigned COEF_N      = COEF_N_DEF,
    parameter int unsigned BIAS_N      = BIAS_N_DEF,
    parameter int unsigned IMG_N       = IMG_N_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid_i,
    input  logic [3:0]        rx_nibble_i,
    output logic              mem_we_o,
    output logic [1:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wdata_o,
    output logic              cnn_start_o,
    input  logic              cnn_done_i,
    output logic              busy_o,
    output logic              params_valid_o,
    output logic              frame_done_o,
    output logic              err_cmd_o,
    output logic              err_timeout_o,
    output logic              err_overrun_o,
    output logic [2:0]        dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(COEF_N - 1);
    localparam logic [ADDR_W-1:0] LAST_BIAS = ADDR_W'(BIAS_N - 1);
    localparam logic [ADDR_W-1:0] LAST_IMG  = ADDR_W'(IMG_N - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_d, start_d, fdone_d, pv_d;
    logic              ecmd_d, etmo_d, eovr_d;
    logic [1:0]        sel_d;
    logic [ADDR_W-1:0] maddr_d;
    logic [3:0]        wdata_d;

    logic [1:0]        cur_sel;
    logic [ADDR_W-1:0] cur_last;
    state_t            cur_next;

    logic in_load, tmr_clear, tmr_expire;

    assign in_load   = (state_q == S_LD_COEF) || (state_q == S_LD_BIAS) ||
                       (state_q == S_LD_IMG);
    // The gap count restarts on every nibble and on every state change.
    assign tmr_clear = rx_valid_i || (state_d != state_q);

    gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (in_load),
        .expire (tmr_expire)
    );

    // Region attributes of the current load state.
    always_comb begin
        cur_sel  = SEL_COEF;
        cur_last = LAST_COEF;
        cur_next = S_LD_BIAS;
        case (state_q)
            S_LD_BIAS: begin
                cur_sel  = SEL_BIAS;
                cur_last = LAST_BIAS;
                cur_next = S_LD_IMG;
            end
            S_LD_IMG: begin
                cur_sel  = SEL_IMG;
                cur_last = LAST_IMG;
                cur_next = S_START;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        sel_d   = mem_sel_o;
        maddr_d = mem_addr_o;
        wdata_d = mem_wdata_o;
        start_d = 1'b0;
        fdone_d = 1'b0;
        pv_d    = params_valid_o;
        ecmd_d  = err_cmd_o;
        etmo_d  = err_timeout_o;
        eovr_d  = err_overrun_o;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_nibble_i == CMD_FULL) begin
                        state_d = S_LD_COEF;
                        pv_d    = 1'b0;
                        addr_d  = '0;
                        ecmd_d  = 1'b0;
                        etmo_d  = 1'b0;
                        eovr_d  = 1'b0;
                    end else if (rx_nibble_i == CMD_IMG && params_valid_o) begin
                        state_d = S_LD_IMG;
                        addr_d  = '0;
                        ecmd_d  = 1'b0;
                        etmo_d  = 1'b0;
                        eovr_d  = 1'b0;
                    end else begin
                        ecmd_d = 1'b1;
                    end
                end
            end
            S_LD_COEF, S_LD_BIAS, S_LD_IMG: begin
                // A nibble arriving in the expiry cycle is still taken.
                if (rx_valid_i) begin
                    we_d    = 1'b1;
                    sel_d   = cur_sel;
                    maddr_d = addr_q;
                    wdata_d = rx_nibble_i;
                    addr_d  = addr_q + 1'b1;
                    if (addr_q == cur_last) begin
                        addr_d  = '0;
                        state_d = cur_next;
                        if (state_q == S_LD_BIAS) pv_d = 1'b1;
                    end
                end else if (tmr_expire) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    etmo_d  = 1'b1;
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_RUN;
                if (rx_valid_i) eovr_d = 1'b1;
            end
            S_RUN: begin
                if (rx_valid_i) eovr_d = 1'b1;
                if (cnn_done_i) begin
                    fdone_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            mem_we_o       <= 1'b0;
            mem_sel_o      <= '0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            cnn_start_o    <= 1'b0;
            frame_done_o   <= 1'b0;
            params_valid_o <= 1'b0;
            err_cmd_o      <= 1'b0;
            err_timeout_o  <= 1'b0;
            err_overrun_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            mem_we_o       <= we_d;
            mem_sel_o      <= sel_d;
            mem_addr_o     <= maddr_d;
            mem_wdata_o    <= wdata_d;
            cnn_start_o    <= start_d;
            frame_done_o   <= fdone_d;
            params_valid_o <= pv_d;
            err_cmd_o      <= ecmd_d;
            err_timeout_o  <= etmo_d;
            err_overrun_o  <= eovr_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
